// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the sync FIFO family.
// Holds read-mode selectors and a constant clog2 for sizing ports.
package fifo_pkg;

  localparam int FIFO_MODE_STANDARD = 0;
  localparam int FIFO_MODE_FWFT     = 1;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, sync write, async read.
// Ports:
//   clk        - write clock
//   write_en   - write strobe for write_addr
//   write_addr - entry written on the rising edge
//   write_data - data written
//   read_addr  - entry presented on read_data
//   read_data  - combinational view of mem[read_addr]
// Contents are deliberately not reset.
module fifo_ram import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [AW-1:0]         write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [AW-1:0]         read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO, any depth >= 2, standard or
// first-word-fall-through read mode, with level flags and error pulses.
// Ports:
//   clk          - clock, all state on the rising edge
//   reset        - asynchronous, active-high clear
//   write_en     - push request, ignored while full
//   write_data   - data pushed
//   read_en      - pop request, ignored while empty
//   read_data    - registered head (standard) or live head (FWFT)
//   full/empty   - count == DEPTH / count == 0
//   almost_full  - count >= ALMOST_FULL_LEVEL
//   almost_empty - count <= ALMOST_EMPTY_LEVEL
//   count        - occupancy 0..DEPTH
//   overflow     - one-cycle pulse after a write attempt while full
//   underflow    - one-cycle pulse after a read attempt while empty
module sync_fifo_flex import fifo_pkg::*; #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 8,
  parameter int FWFT               = FIFO_MODE_STANDARD,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  localparam int CW                = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = (CW - 1 < 1) ? 1 : CW - 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  if (DEPTH < 2 ||
      ALMOST_FULL_LEVEL < 1 ||
      ALMOST_FULL_LEVEL > DEPTH ||
      ALMOST_EMPTY_LEVEL < 0 ||
      ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_params
    $fatal(1, "sync_fifo_flex: illegal DEPTH or threshold parameters");
  end

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr_nxt;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] head;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = write_en && !full;
  assign rd_ok = read_en && !empty;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  assign wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
  assign rd_ptr_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk        (clk),
    .write_en   (wr_ok),
    .write_addr (wr_ptr),
    .write_data (write_data),
    .read_addr  (rd_ptr),
    .read_data  (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= write_en && full;
      underflow <= read_en && empty;
    end
  end

  // Flags are pure decodes of the registered count.
  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign read_data = empty ? '0 : head;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q <= '0;
      end else if (rd_ok) begin
        rd_q <= head;
      end
    end

    assign read_data = rd_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: table, directed and random checks of both read
// modes against a queue model of FIFO behaviour.
module tb_sync_fifo_flex;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int AFL   = 5;
  localparam int AEL   = 1;
  localparam int CW    = clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_en;
  logic [DW-1:0] write_data;
  logic          read_en;

  logic [DW-1:0] s_rd, f_rd;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae;
  logic [CW-1:0] s_cnt, f_cnt;
  logic          s_ov, f_ov, s_un, f_un;

  always #5 clk = ~clk;

  sync_fifo_flex #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(FIFO_MODE_STANDARD),
    .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) dut_std (
    .clk(clk), .reset(reset),
    .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(s_rd),
    .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_flex #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(FIFO_MODE_FWFT),
    .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) dut_fw (
    .clk(clk), .reset(reset),
    .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(f_rd),
    .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ov), .underflow(f_un)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_std;
  logic          m_ov, m_un;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_std = '0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  // One clock edge of FIFO behaviour, from the current inputs.
  task automatic model_edge();
    bit pf, pe, ar, aw;
    pf = (q.size() == DEPTH);
    pe = (q.size() == 0);
    ar = read_en && !pe;
    aw = write_en && !pf;
    m_ov = write_en && pf;
    m_un = read_en && pe;
    if (ar) m_rd_std = q.pop_front();
    if (aw) q.push_back(write_data);
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [DW-1:0] hd;
    n = q.size();
    hd = (n > 0) ? q[0] : '0;
    chk({tag, " count_std"}, s_cnt, n);
    chk({tag, " count_fw"}, f_cnt, n);
    chk({tag, " full"}, {s_full, f_full}, {2{n == DEPTH}});
    chk({tag, " empty"}, {s_empty, f_empty}, {2{n == 0}});
    chk({tag, " almost_full"}, {s_af, f_af}, {2{n >= AFL}});
    chk({tag, " almost_empty"}, {s_ae, f_ae}, {2{n <= AEL}});
    chk({tag, " overflow"}, {s_ov, f_ov}, {2{m_ov}});
    chk({tag, " underflow"}, {s_un, f_un}, {2{m_un}});
    chk({tag, " rd_std"}, s_rd, m_rd_std);
    chk({tag, " rd_fwft"}, f_rd, hd);
  endtask

  // Drive before the rising edge, update the model, settle at negedge.
  task automatic step(input logic we, input logic [DW-1:0] wd,
                      input logic re);
    write_en = we;
    write_data = wd;
    read_en = re;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic          we;
    logic          re;
    logic [DW-1:0] wd;
    int            cnt;
    logic          full, empty, af, ae, ov, un;
    logic [DW-1:0] rd_s;
    logic [DW-1:0] rd_f;
  } vec_t;

  function automatic vec_t mk(
    logic we, logic re, logic [DW-1:0] wd, int cnt,
    logic full, logic empty, logic af, logic ae,
    logic ov, logic un, logic [DW-1:0] rd_s, logic [DW-1:0] rd_f);
    vec_t v;
    v.we = we; v.re = re; v.wd = wd; v.cnt = cnt;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.ov = ov; v.un = un; v.rd_s = rd_s; v.rd_f = rd_f;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    // fill i*8'h44, overflow, drain, underflow, idle
    tbl[0]  = mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    tbl[1]  = mk(1, 0, 8'h44, 2, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[2]  = mk(1, 0, 8'h88, 3, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[3]  = mk(1, 0, 8'hCC, 4, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[4]  = mk(1, 0, 8'h10, 5, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    tbl[5]  = mk(1, 0, 8'h54, 6, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    tbl[6]  = mk(1, 0, 8'h99, 6, 1, 0, 1, 0, 1, 0, 8'h00, 8'h00);
    tbl[7]  = mk(0, 1, 8'h00, 5, 0, 0, 1, 0, 0, 0, 8'h00, 8'h44);
    tbl[8]  = mk(0, 1, 8'h00, 4, 0, 0, 0, 0, 0, 0, 8'h44, 8'h88);
    tbl[9]  = mk(0, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0, 8'h88, 8'hCC);
    tbl[10] = mk(0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 0, 8'hCC, 8'h10);
    tbl[11] = mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h10, 8'h54);
    tbl[12] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h54, 8'h00);
    tbl[13] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 8'h54, 8'h00);
    tbl[14] = mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h54, 8'h00);

    reset = 1'b1;
    write_en = 1'b0;
    write_data = '0;
    read_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("por");
    reset = 1'b0;

    // Reset mid-fill, checked before any further clock edge.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h30 + i), 1'b0);
    check_model("prefill");
    write_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midrst count", s_cnt, 0);
    chk("midrst empty", {s_empty, f_empty}, 2'b11);
    chk("midrst almost_empty", {s_ae, f_ae}, 2'b11);
    chk("midrst full", {s_full, f_full}, 2'b00);
    chk("midrst rd_std", s_rd, 0);
    chk("midrst rd_fwft", f_rd, 0);
    reset = 1'b0;
    step(1'b0, '0, 1'b1);
    chk("rst underflow", {s_un, f_un}, 2'b11);
    check_model("rst_rd");
    step(1'b0, '0, 1'b0);
    chk("rst underflow clear", {s_un, f_un}, 2'b00);

    // Table: fill, overflow, drain, underflow.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].we, tbl[i].wd, tbl[i].re);
      chk($sformatf("tbl%0d count", i), s_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d count_fw", i), f_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d flags", i),
          {s_full, s_empty, s_af, s_ae, s_ov, s_un},
          {tbl[i].full, tbl[i].empty, tbl[i].af,
           tbl[i].ae, tbl[i].ov, tbl[i].un});
      chk($sformatf("tbl%0d flags_fw", i),
          {f_full, f_empty, f_af, f_ae, f_ov, f_un},
          {tbl[i].full, tbl[i].empty, tbl[i].af,
           tbl[i].ae, tbl[i].ov, tbl[i].un});
      chk($sformatf("tbl%0d rd_std", i), s_rd, tbl[i].rd_s);
      chk($sformatf("tbl%0d rd_fwft", i), f_rd, tbl[i].rd_f);
    end

    // Wrap-around: offset pointers, then a full pass of A0..A5.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h70 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, DW'(8'hA0 + i), 1'b0);
      check_model("wrap_wr");
    end
    chk("wrap full", {s_full, f_full}, 2'b11);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1);
      check_model("wrap_rd");
      chk("wrap order", s_rd, DW'(8'hA0 + i));
    end

    // Simultaneous read/write at mid level, full and empty.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, DW'(8'hC0 + i), 1'b1);
      check_model("both_mid");
    end
    chk("both_mid count", s_cnt, 3);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hD0 + i), 1'b0);
    chk("pre_both full", s_full, 1'b1);
    step(1'b1, 8'hEE, 1'b1);
    check_model("both_full");
    chk("both_full count", s_cnt, 5);
    chk("both_full overflow", s_ov, 1'b1);
    while (q.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    check_model("both_empty");
    chk("both_empty count", f_cnt, 1);
    chk("both_empty underflow", f_un, 1'b1);
    step(1'b0, '0, 1'b1);
    check_model("drain");

    // First-word fall-through without read_en.
    step(1'b1, 8'h11, 1'b0);
    chk("fwft first", f_rd, 8'h11);
    step(1'b1, 8'h22, 1'b0);
    chk("fwft hold", f_rd, 8'h11);
    step(1'b0, '0, 1'b1);
    chk("fwft pop1", f_rd, 8'h22);
    step(1'b0, '0, 1'b1);
    chk("fwft pop2 empty", f_empty, 1'b1);
    chk("fwft pop2 data", f_rd, 8'h00);
    check_model("fwft");

    // Random traffic with shifting bias and rare async resets.
    for (int i = 0; i < 800; i++) begin
      int wb;
      wb = ((i / 100) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 199) == 0) begin
        write_en = 1'b0;
        read_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model("rnd_rst");
        reset = 1'b0;
      end
      step($urandom_range(0, 99) < wb, DW'($urandom),
           $urandom_range(0, 99) < (100 - wb));
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
